// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stage indices,
// stall patterns and divider FSM encoding.
package stall_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam logic [5:0] STALL_LD  = 6'b000111;
    localparam logic [5:0] STALL_DIV = 6'b001111;
    localparam logic [5:0] STALL_MEM = 6'b011111;

    // Counter wide enough for the largest legal DIV_LAT (63).
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_BUSY = 2'd1,
        ST_DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/stall_ctrl_div_timer.sv
// Fixed-latency divider occupancy tracker: counts DIV_LAT busy cycles after
// an accepted div_start and holds the done state while MEM is waiting.
module div_timer
    import stall_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic div_start_i,
    input  logic mem_busy_i,
    output logic div_busy_o,
    output logic div_done_o,
    output logic div_stall_req_o
);

    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_LAT - 1);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // A divide arriving under a MEM wait is retried next cycle.
                if (div_start_i && !mem_busy_i) begin
                    state_d = ST_DIV_BUSY;
                    cnt_d   = '0;
                end
            end
            ST_DIV_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_DIV_DONE;
            end
            ST_DIV_DONE: begin
                if (!mem_busy_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign div_busy_o      = (state_q == ST_DIV_BUSY);
    assign div_done_o      = (state_q == ST_DIV_DONE);
    assign div_stall_req_o = (state_q == ST_DIV_BUSY) ||
                             ((state_q == ST_IDLE) && div_start_i);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall controller: load-use detection, divider occupancy
// and MEM wait, merged by priority into per-stage stall and bubble vectors.
module stall_ctrl #(
    parameter int DIV_LAT = 32,
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_re1,
    input  logic [4:0]         id_raddr1,
    input  logic               id_re2,
    input  logic [4:0]         id_raddr2,
    input  logic               ex_rf_we,
    input  logic [4:0]         ex_rf_waddr,
    input  logic               ex_is_load,
    input  logic               div_start,
    input  logic               mem_busy,
    output logic [STALL_W-1:0] stall,
    output logic [STALL_W-1:0] bubble,
    output logic               div_busy,
    output logic               div_done
);
    import stall_ctrl_pkg::*;

    logic div_stall_req;
    logic ld_hz;

    div_timer #(
        .DIV_LAT (DIV_LAT)
    ) u_div_timer (
        .clk             (clk),
        .rst             (rst),
        .div_start_i     (div_start),
        .mem_busy_i      (mem_busy),
        .div_busy_o      (div_busy),
        .div_done_o      (div_done),
        .div_stall_req_o (div_stall_req)
    );

    // Only loads need a stall; ALU results are forwarded from EX directly.
    assign ld_hz = ex_is_load && ex_rf_we && (ex_rf_waddr != 5'd0) &&
                   ((id_re1 && (id_raddr1 == ex_rf_waddr)) ||
                    (id_re2 && (id_raddr2 == ex_rf_waddr)));

    always_comb begin
        stall = '0;
        // Held reset forces a quiet pipeline even with requests pending.
        if (rst)                stall = '0;
        else if (mem_busy)      stall = STALL_W'(STALL_MEM);
        else if (div_stall_req) stall = STALL_W'(STALL_DIV);
        else if (ld_hz)         stall = STALL_W'(STALL_LD);
    end

    // A NOP enters the first stage that advances behind a held stage.
    assign bubble[STG_PC] = 1'b0;
    for (genvar k = 1; k < STALL_W; k++) begin : g_bubble
        assign bubble[k] = stall[k-1] & ~stall[k];
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl with a cycle-level reference model of the
// divider occupancy and stall priority.
module tb_stall_ctrl;
    localparam int DIV_LAT = 32;
    localparam int SW      = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_re1, id_re2, ex_rf_we, ex_is_load, div_start, mem_busy;
    logic [4:0]    id_raddr1, id_raddr2, ex_rf_waddr;
    logic [SW-1:0] stall, bubble;
    logic          div_busy, div_done;

    int vectors = 0;
    int errors  = 0;

    stall_ctrl #(.DIV_LAT(DIV_LAT), .STALL_W(SW)) dut (
        .clk(clk), .rst(rst),
        .id_re1(id_re1), .id_raddr1(id_raddr1),
        .id_re2(id_re2), .id_raddr2(id_raddr2),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_is_load(ex_is_load),
        .div_start(div_start), .mem_busy(mem_busy),
        .stall(stall), .bubble(bubble),
        .div_busy(div_busy), .div_done(div_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles plus a done-pending flag.
    int m_left = 0;
    bit m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
        end else if (m_done) begin
            if (!mem_busy) m_done = 1'b0;
        end else if (div_start && !mem_busy) begin
            m_left = DIV_LAT;
        end
    end

    always @(negedge clk) begin
        logic          ld, dreq;
        logic [SW-1:0] es, eb;
        if (!rst) begin
            ld = ex_is_load && ex_rf_we && ex_rf_waddr != 0 &&
                 ((id_re1 && id_raddr1 == ex_rf_waddr) || (id_re2 && id_raddr2 == ex_rf_waddr));
            dreq = (m_left > 0) || (m_left == 0 && !m_done && div_start);
            if (mem_busy)  begin es = 6'b011111; eb = 6'b100000; end
            else if (dreq) begin es = 6'b001111; eb = 6'b010000; end
            else if (ld)   begin es = 6'b000111; eb = 6'b001000; end
            else           begin es = 6'b000000; eb = 6'b000000; end
            chk("model_stall",    32'(stall),    32'(es));
            chk("model_bubble",   32'(bubble),   32'(eb));
            chk("model_div_busy", 32'(div_busy), 32'(m_left > 0));
            chk("model_div_done", 32'(div_done), 32'(m_done));
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_in;
        id_re1 = 0; id_raddr1 = 0; id_re2 = 0; id_raddr2 = 0;
        ex_rf_we = 0; ex_rf_waddr = 0; ex_is_load = 0;
        div_start = 0; mem_busy = 0;
    endtask

    // Counts consecutive divide-stall cycles starting now; bounded.
    task automatic count_div(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            at_neg();
            if (stall != 6'b001111) break;
            n++;
            nxt();
        end
    endtask

    initial begin
        int n;
        idle_in();
        rst = 1;
        at_neg();
        chk("reset_stall",  32'(stall),    0);
        chk("reset_bubble", 32'(bubble),   0);
        chk("reset_busy",   32'(div_busy), 0);
        chk("reset_done",   32'(div_done), 0);
        nxt();
        rst = 0;

        // Load-use on port 2
        ex_is_load = 1; ex_rf_we = 1; ex_rf_waddr = 8; id_re2 = 1; id_raddr2 = 8;
        at_neg();
        chk("ld_use_stall",  32'(stall),  32'h07);
        chk("ld_use_bubble", 32'(bubble), 32'h08);
        nxt();
        ex_is_load = 0; ex_rf_waddr = 9;
        at_neg();
        chk("ld_use_released", 32'(stall), 0);

        // Register 0 never hazards
        nxt();
        ex_is_load = 1; ex_rf_waddr = 0; id_raddr2 = 0;
        at_neg();
        chk("ld_r0_stall", 32'(stall), 0);

        // Match on port 1 but re1 low: no hazard
        nxt();
        idle_in();
        ex_is_load = 1; ex_rf_we = 1; ex_rf_waddr = 5; id_raddr1 = 5;
        at_neg();
        chk("ld_re_off_stall", 32'(stall), 0);

        // Non-load producer is forwarded
        nxt();
        idle_in();
        ex_rf_we = 1; ex_rf_waddr = 8; id_re1 = 1; id_raddr1 = 8;
        at_neg();
        chk("alu_fwd_stall", 32'(stall), 0);

        // Full divide, start held throughout
        nxt();
        idle_in();
        div_start = 1;
        count_div(n);
        chk("div_stall_cycles", n, 33);
        chk("div_done_flag",    32'(div_done), 1);
        chk("div_done_stall",   32'(stall),    0);
        nxt();
        at_neg();
        chk("div2_accept_stall", 32'(stall),    32'h0F);
        chk("div2_accept_busy",  32'(div_busy), 0);
        nxt();
        at_neg();
        chk("div2_busy", 32'(div_busy), 1);

        // Busy count is 0 now; advance to count 30, then MEM waits 3 cycles
        for (int i = 0; i < 30; i++) nxt();
        mem_busy = 1;
        at_neg();
        chk("memdiv_stall",  32'(stall),    32'h1F);
        chk("memdiv_bubble", 32'(bubble),   32'h20);
        chk("memdiv_busy",   32'(div_busy), 1);
        nxt();
        at_neg();
        chk("memdiv_stall2", 32'(stall), 32'h1F);
        nxt();
        at_neg();
        chk("memdone_hold_done",  32'(div_done), 1);
        chk("memdone_hold_stall", 32'(stall),    32'h1F);
        nxt();
        mem_busy = 0; div_start = 0;
        at_neg();
        chk("memdone_release_done",  32'(div_done), 1);
        chk("memdone_release_stall", 32'(stall),    0);
        nxt();
        at_neg();
        chk("after_done_idle", 32'(div_done), 0);

        // Priority: mem over divide over load-use; divide not accepted
        nxt();
        mem_busy = 1; div_start = 1;
        ex_is_load = 1; ex_rf_we = 1; ex_rf_waddr = 3; id_re1 = 1; id_raddr1 = 3;
        at_neg();
        chk("prio_stall",  32'(stall),  32'h1F);
        chk("prio_bubble", 32'(bubble), 32'h20);
        nxt();
        mem_busy = 0;
        at_neg();
        chk("prio_not_accepted", 32'(div_busy), 0);
        chk("retry_stall",       32'(stall),    32'h0F);
        nxt();
        at_neg();
        chk("retry_busy",     32'(div_busy), 1);
        chk("ld_masked_bub",  32'(bubble),   32'h10);

        // Reset mid-divide: outputs clear before the next edge
        for (int i = 0; i < 3; i++) nxt();
        rst = 1;
        #1;
        chk("rst_mid_stall",  32'(stall),    0);
        chk("rst_mid_bubble", 32'(bubble),   0);
        chk("rst_mid_busy",   32'(div_busy), 0);
        nxt();
        rst = 0;
        idle_in();
        div_start = 1;
        count_div(n);
        chk("restart_cycles", n, 33);
        chk("restart_done",   32'(div_done), 1);
        nxt();
        idle_in();
        for (int i = 0; i < 3; i++) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Central pipeline hazard and stall controller for the 5-stage CPU core.
- Produces the per-stage stall and bubble vectors that sequence the register-file forwarding datapath.
- Handles three cases: load-use hazards (EX-stage load data cannot yet be forwarded to ID), fixed-latency divider occupancy in EX, and data-memory wait requests in MEM.
- Sits beside the ID/EX/MEM pipeline registers; every stage register consumes stall[k]/bubble[k].

Parameters:
- DIV_LAT, 32, divider latency in cycles from accepted div_start to result valid (legal range 2..63).
- STALL_W, 6, stall/bubble vector width. Bit mapping: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_re1  in  1  ID reads source port 1
- id_raddr1  in  5  ID source register 1
- id_re2  in  1  ID reads source port 2
- id_raddr2  in  5  ID source register 2
- ex_rf_we  in  1  EX instruction writes the register file
- ex_rf_waddr  in  5  EX destination register
- ex_is_load  in  1  EX instruction is a load
- div_start  in  1  divide instruction present in EX (level, held while EX is stalled)
- mem_busy  in  1  data memory not ready; MEM must hold
- stall  out  STALL_W  stall[k]=1: stage k register holds its contents
- bubble  out  STALL_W  bubble[k]=1: stage k register loads a NOP
- div_busy  out  1  divider occupied (state DIV_BUSY)
- div_done  out  1  divider result valid this cycle (state DIV_DONE)

Behaviour:
- Reset (async, immediate): state IDLE, div counter 0, stall=0, bubble=0, div_busy=0, div_done=0. Reset asserted mid-divide abandons the operation; there is no resume.
- FSM states: IDLE, DIV_BUSY, DIV_DONE.
  - IDLE -> DIV_BUSY when div_start & ~mem_busy. Counter loads 0.
  - DIV_BUSY: counter increments each cycle, independent of mem_busy. When counter==DIV_LAT-1, go to DIV_DONE.
  - DIV_DONE: div_done=1. Go to IDLE when ~mem_busy; otherwise hold DIV_DONE.
  - div_start is ignored in DIV_BUSY and DIV_DONE, because it is the same instruction.
  - A back-to-back divide is accepted in the IDLE cycle after DIV_DONE.
- Load-use hazard, combinational: ld_hz = ex_is_load & ex_rf_we & (ex_rf_waddr!=0) & ((id_re1 & id_raddr1==ex_rf_waddr) | (id_re2 & id_raddr2==ex_rf_waddr)).
  - Reads of register 0 never cause a hazard.
- Stall selection, combinational from current state and inputs. Highest priority first:
  - mem_busy: stall=6'b011111.
  - state DIV_BUSY, or (state IDLE & div_start): stall=6'b001111.
  - ld_hz: stall=6'b000111.
  - otherwise: stall=0.
- In DIV_DONE without mem_busy, EX is released (stall[3]=0) in that same cycle.
- Bubble rule for k=1..5: bubble[k]=stall[k-1] & ~stall[k]. bubble[0]=0.
  - Resulting patterns: load-use gives bubble=6'b001000 (NOP into EX); divide gives 6'b010000; mem wait gives 6'b100000.
- Latencies:
  - Load-use costs exactly 1 stall cycle: after the load advances to MEM, ld_hz drops and MEM-stage forwarding supplies the data.
  - A divide with no mem_busy costs DIV_LAT+1 stalled cycles: the accept cycle plus DIV_LAT busy cycles. EX advances in the DIV_DONE cycle.
- Simultaneous events:
  - mem_busy during DIV_BUSY: counter keeps running; the mem pattern applies.
  - mem_busy at the first div_start cycle: the divide is not accepted and is retried next cycle.
  - Load-use while the divider is busy is masked by the divider stall, then re-evaluated.
- All outputs are glitch-free decodes of registered state plus same-cycle inputs; there is no extra pipeline latency.

Decomposition:
- Shared package/defines:
  - STALL_W.
  - Stage bit indices STG_PC..STG_WB.
  - Stall patterns STALL_LD=6'b000111, STALL_DIV=6'b001111, STALL_MEM=6'b011111.
  - FSM state encodings.
- One natural sub-module: div_timer (counter plus IDLE/DIV_BUSY/DIV_DONE FSM, outputs div_busy/div_done/div_stall_req). Hazard detection and priority muxing stay in stall_ctrl.

Test Plan:
- Reset mid-divide: div_start for 5 cycles, then rst pulse -> stall=0, bubble=0, div_busy=0 immediately (before next clk edge); next div_start restarts the full count.
- Load-use: ex_is_load=1, ex_rf_we=1, ex_rf_waddr=8, id_re2=1, id_raddr2=8 -> stall=6'b000111, bubble=6'b001000 for one cycle. Same stimulus with waddr=0 -> stall=0.
- Non-load forward: ex_is_load=0, waddr=8 matches raddr1=8 -> stall=0 (forwarding covers it).
- Divide, DIV_LAT=32, div_start held: stall=6'b001111 for 33 cycles; div_done=1 on cycle 34 with stall=0; a second div_start the next cycle is accepted.
- mem_busy for 3 cycles during DIV_BUSY at count 30: stall=6'b011111 for those cycles; state holds DIV_DONE until mem_busy falls, then div_done and EX release coincide.
- Priority: mem_busy=1 with ld_hz=1 and div_start=1 in IDLE -> stall=6'b011111, bubble=6'b100000, divide not accepted (div_busy stays 0).
